// File: rtl/mux2_1_rr_arbiter_if.sv
// mux2_1_rr_arbiter_if: bundles both requester handshakes, the output handshake and the grant select
interface mux2_1_rr_arbiter_if #(
    parameter int WIDTH = 2
);
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             in2_valid;
    logic [WIDTH-1:0] in2_data;
    logic             in2_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             selector;

    modport master (
        output in1_valid, in1_data, in2_valid, in2_data, out_ready,
        input  in1_ready, in2_ready, out_valid, out_data, selector
    );

    modport slave (
        input  in1_valid, in1_data, in2_valid, in2_data, out_ready,
        output in1_ready, in2_ready, out_valid, out_data, selector
    );
endinterface

// File: rtl/mux2_1_rr_arbiter.sv
// mux2_1_rr_arbiter: two-requester bounded-burst round-robin arbiter feeding a one-entry registered output stage
module mux2_1_rr_arbiter #(
    parameter int WIDTH = 2,
    parameter int BURST = 4
) (
    input logic                clk,
    input logic                reset,
    mux2_1_rr_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST);

    typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

    state_t           state_q, state_d, own;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             accept, grant, grant_valid;

    // choose the winner (grant=1 means in2), then derive owner/count and output-stage updates
    always_comb begin
        accept      = !out_valid_q || bus.out_ready;
        grant       = (bus.in1_valid && bus.in2_valid)
                    ? (state_q == OWN1 ? (cnt_q >= CNT_MAX) : state_q == OWN2 ? (cnt_q < CNT_MAX) : 1'b0)
                    : bus.in2_valid;
        grant_valid = !reset && accept && (bus.in1_valid || bus.in2_valid);
        own         = grant ? OWN2 : OWN1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) out_valid_d = grant_valid;
        if (grant_valid) begin
            out_data_d = grant ? bus.in2_data : bus.in1_data;
            sel_d      = grant;
            if (state_q == own) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                state_d = own;
                cnt_d   = CW'(1);
            end
        end
    end

    // owner FSM, burst counter, remembered select and output register; reset drops any in-flight word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in1_ready = grant_valid && !grant;
    assign bus.in2_ready = grant_valid && grant;
    assign bus.selector  = grant_valid ? grant : sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule
